muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide unit that sits beside the single-cycle ALU in the execute stage.
//  - Takes RV32M funct3 ops that the ALU cannot complete in one cycle.
//  - Decoder/pipeline raises I_valid and stalls on !O_ready; result returns with a one-cycle O_valid pulse.
//  - One operation in flight; shift-add multiply, restoring divide, one bit per cycle.
// PARAMETERS
//  WIDTH   32   operand/result width; CALC iteration count = WIDTH
// PORTS
//  I_clk      in   1      clock; all state changes on rising edge
//  I_rst      in   1      synchronous, active-high reset
//  I_valid    in   1      request; accepted on a rising edge where I_valid && O_ready
//  I_op       in   3      RV32M funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  I_data1    in   WIDTH  rs1 operand (dividend / multiplicand)
//  I_data2    in   WIDTH  rs2 operand (divisor / multiplier)
//  O_ready    out  1      high only in IDLE; unit can accept a request
//  O_valid    out  1      one-cycle pulse; O_data valid while high
//  O_data     out  WIDTH  result; holds last value until next completion
// BEHAVIOUR
//  Reset: state=IDLE, O_ready=1, O_valid=0, O_data=0, counter=0. Reset mid-operation aborts; no O_valid.
//  FSM: IDLE -(accept)-> CALC -(count==0)-> DONE -> IDLE.
//   - IDLE: latch I_op and operands on accept.
//     - Take magnitudes of signed operands (MULH: both, MULHSU: rs1 only, DIV/REM: both).
//     - Record result sign; load counter = WIDTH-1.
//   - CALC: one partial-product add / trial-subtract per cycle. Decrement counter; O_ready=0.
//   - DONE: apply sign correction; register O_data; O_valid=1 for exactly this cycle; O_ready=0.
//  Latency: accept edge at t0; O_valid high in cycle t0+WIDTH+1 (33 for WIDTH=32).
//   - Next accept possible at the edge ending DONE+1, i.e. in IDLE again.
//  I_valid while !O_ready: ignored, not queued. Inputs are sampled only at the accept edge.
//  Multiply: 2*WIDTH-bit product. MUL returns low WIDTH bits; MULH/MULHSU/MULHU return high WIDTH bits.
//  Divide: quotient truncates toward zero. Remainder takes the dividend's sign.
//  Divide by zero: DIV/DIVU -> all ones (0xFFFFFFFF); REM/REMU -> dividend unchanged.
//  Signed overflow (0x80000000 / -1): DIV -> 0x80000000; REM -> 0.
//  Corner cases are resolved at DONE, after full CALC, unless the optional feature is enabled.
//  Undefined I_op values: none, because all 8 encodings are legal.
// CONFIGURATION
//  MULDIV_EARLY_OUT_EN defined:
//   - IDLE goes directly to DONE for: divisor==0, signed overflow, or either multiply operand==0.
//   - O_valid is then high at t0+1.
//   - All other ops unchanged (t0+WIDTH+1).
//  Not defined: every op takes the full WIDTH+1 latency; no bypass logic is built.
//  Results are identical in both builds; only timing differs.
// TESTING
//  MUL 7 x -3 -> O_data=0xFFFFFFEB; O_valid exactly at t0+33, single cycle.
//  MULH/MULHSU/MULHU with 0x80000000 x 0xFFFFFFFF:
//   - MULH -> 0x00000000
//   - MULHSU -> 0x80000000
//   - MULHU -> 0x7FFFFFFF
//  DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
//  DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000.
//   - With MULDIV_EARLY_OUT_EN these cases give O_valid at t0+1.
//  Assert I_valid continuously during CALC -> no extra accept. Back-to-back accept occurs only when O_ready=1.
//  Assert I_rst at t0+10 of a DIV -> next cycle IDLE, O_ready=1, O_data=0; no O_valid pulse follows.

Source files
------------

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit (shift-add multiply, restoring divide)
// Optional feature: MULDIV_EARLY_OUT_EN bypasses CALC for divide-by-zero, signed overflow and zero multiply operands.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             I_clk,
    input  logic             I_rst,
    input  logic             I_valid,
    input  logic [2:0]       I_op,
    input  logic [WIDTH-1:0] I_data1,
    input  logic [WIDTH-1:0] I_data2,
    output logic             O_ready,
    output logic             O_valid,
    output logic [WIDTH-1:0] O_data
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_e;

    state_e                 state_q;
    logic [2:0]             op_q;
    logic [CW-1:0]          cnt_q;
    logic [WIDTH-1:0]       a_q;
    logic [2*WIDTH-1:0]     acc_q;
    logic                   neg_q;
    logic                   div0_q;
    logic                   ready_q;
    logic                   valid_q;
    logic [WIDTH-1:0]       data_q;

    logic                   s1_d;
    logic                   s2_d;
    logic                   neg_d;
    logic [WIDTH-1:0]       mag1_d;
    logic [WIDTH-1:0]       mag2_d;

    logic [WIDTH:0]         mul_sum;
    logic [WIDTH:0]         r_shift;
    logic [WIDTH+1:0]       diff;
    logic                   div_ok;
    logic [2*WIDTH-1:0]     acc_d;
    logic [2*WIDTH-1:0]     prod_d;
    logic [WIDTH-1:0]       quo_d;
    logic [WIDTH-1:0]       rem_d;
    logic [WIDTH-1:0]       result_d;

    assign O_ready = ready_q;
    assign O_valid = valid_q;
    assign O_data  = data_q;

    // Operand conditioning at accept: magnitudes plus the sign the result must carry.
    always_comb begin
        s1_d   = I_data1[WIDTH-1] & ((I_op == OP_MULH) | (I_op == OP_MULHSU) |
                                     (I_op == OP_DIV)  | (I_op == OP_REM));
        s2_d   = I_data2[WIDTH-1] & ((I_op == OP_MULH) | (I_op == OP_DIV) | (I_op == OP_REM));
        mag1_d = s1_d ? -I_data1 : I_data1;
        mag2_d = s2_d ? -I_data2 : I_data2;
        neg_d  = (I_op == OP_REM) ? s1_d : (s1_d ^ s2_d);
    end

    // One iteration: multiply keeps {hi, multiplier} shifting right; divide keeps {rem, quotient} shifting left.
    always_comb begin
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
        r_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff    = {1'b0, r_shift} - {2'b00, a_q};
        div_ok  = ~diff[WIDTH+1];
        if (op_q[2]) begin
            acc_d = {(div_ok ? diff[WIDTH-1:0] : r_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ok};
        end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod_d   = neg_q ? -acc_d : acc_d;
        quo_d    = acc_d[WIDTH-1:0];
        rem_d    = acc_d[2*WIDTH-1:WIDTH];
        result_d = '0;
        case (op_q)
            OP_MUL:                       result_d = prod_d[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod_d[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:              result_d = div0_q ? '1 : (neg_q ? -quo_d : quo_d);
            OP_REM, OP_REMU:              result_d = neg_q ? -rem_d : rem_d;
            default:                      result_d = '0;
        endcase
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic             early_d;
    logic [WIDTH-1:0] early_res_d;
    logic             div0_in;
    logic             ovf_in;

    always_comb begin
        div0_in     = (I_data2 == '0);
        ovf_in      = (I_data1 == {1'b1, {(WIDTH-1){1'b0}}}) && (I_data2 == '1) &&
                      ((I_op == OP_DIV) || (I_op == OP_REM));
        early_d     = I_op[2] ? (div0_in | ovf_in) : ((I_data1 == '0) | (I_data2 == '0));
        early_res_d = '0;
        if (I_op[2]) begin
            if (div0_in) begin
                early_res_d = I_op[1] ? I_data1 : '1;
            end else begin
                early_res_d = I_op[1] ? '0 : I_data1;
            end
        end
    end
`endif

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            div0_q  <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    valid_q <= 1'b0;
                    if (I_valid) begin
                        op_q    <= I_op;
                        cnt_q   <= CW'(WIDTH-1);
                        neg_q   <= neg_d;
                        div0_q  <= (I_data2 == '0);
                        ready_q <= 1'b0;
                        a_q     <= I_op[2] ? mag2_d : mag1_d;
                        acc_q   <= {{WIDTH{1'b0}}, (I_op[2] ? mag1_d : mag2_d)};
`ifdef MULDIV_EARLY_OUT_EN
                        if (early_d) begin
                            data_q  <= early_res_d;
                            valid_q <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_CALC;
                        end
`else
                        state_q <= S_CALC;
`endif
                    end
                end
                S_CALC: begin
                    acc_q <= acc_d;
                    if (cnt_q == '0) begin
                        data_q  <= result_d;
                        valid_q <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_DONE: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;

    localparam int W = 32;
`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         valid;
    logic [2:0]   op;
    logic [W-1:0] d1;
    logic [W-1:0] d2;
    logic         ready_o;
    logic         valid_o;
    logic [W-1:0] data_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .I_clk   (clk),
        .I_rst   (rst),
        .I_valid (valid),
        .I_op    (op),
        .I_data1 (d1),
        .I_data2 (d2),
        .O_ready (ready_o),
        .O_valid (valid_o),
        .O_data  (data_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint     sa = longint'($signed(a));
        longint     sb = longint'($signed(b));
        longint     ua = longint'({32'b0, a});
        longint     ub = longint'({32'b0, b});
        logic [63:0] p;
        case (o)
            3'd0: begin p = 64'(sa * sb); return p[31:0];  end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return 32'(ua / ub);
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            default: begin
                if (b == 32'd0) return a;
                return 32'(ua % ub);
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        bit early;
        if (o[2]) early = (b == 32'd0) ||
                          ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        else      early = (a == 32'd0) || (b == 32'd0);
        return (EARLY && early) ? 1 : W + 1;
    endfunction

    // Reference: cycles remaining until the unit is idle again, and the result it will present.
    int          left = 0;
    logic [31:0] pend_data = 32'd0;
    logic [31:0] exp_data = 32'd0;
    bit          model_ok = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            left     <= 0;
            exp_data <= 32'd0;
            model_ok <= 1'b1;
        end else if (left == 0) begin
            if (valid) begin
                left      <= ref_latency(op, d1, d2);
                pend_data <= ref_result(op, d1, d2);
                if (ref_latency(op, d1, d2) == 1) exp_data <= ref_result(op, d1, d2);
            end
        end else begin
            left <= left - 1;
            if (left == 2) exp_data <= pend_data;
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("ready", {31'b0, ready_o}, {31'b0, (left == 0)});
            check("valid", {31'b0, valid_o}, {31'b0, (left == 1)});
            check("data", data_o, exp_data);
        end
    end

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit hold, input bit lit_en, input logic [31:0] lit);
        int lat;
        int n;
        bit seen;
        lat   = ref_latency(o, a, b);
        op    = o;
        d1    = a;
        d2    = b;
        valid = 1'b1;
        @(posedge clk);
        #1;
        if (hold) begin
            op = 3'($urandom_range(0, 7));
            d1 = $urandom;
            d2 = $urandom;
        end else begin
            valid = 1'b0;
        end
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (valid_o) seen = 1'b1;
        end
        check("done_seen", {31'b0, seen}, 32'd1);
        check("latency", n, lat);
        if (lit_en) check("literal", data_o, lit);
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    localparam int NT = 14;
    logic [2:0]  t_op [NT] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7,
                               3'd4, 3'd6, 3'd4, 3'd6, 3'd0, 3'd7};
    logic [31:0] t_a  [NT] = '{32'd7, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                               32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                               32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'hFFFF_FFFB};
    logic [31:0] t_b  [NT] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'd2, 32'd2, 32'd7, 32'd7,
                               32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd12345, 32'd0};
    logic [31:0] t_r  [NT] = '{32'hFFFF_FFEB, 32'h0000_0000, 32'h8000_0000, 32'h7FFF_FFFF,
                               32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                               32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'd0, 32'hFFFF_FFFB};

    initial begin
        int pulses;
        rst   = 1'b1;
        valid = 1'b0;
        op    = 3'd0;
        d1    = '0;
        d2    = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_ready", {31'b0, ready_o}, 32'd1);
        check("reset_valid", {31'b0, valid_o}, 32'd0);
        check("reset_data", data_o, 32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < NT; i++) begin
            run_op(t_op[i], t_a[i], t_b[i], (i % 3) == 0, 1'b1, t_r[i]);
        end

        for (int i = 0; i < 120; i++) begin
            run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
                   $urandom_range(0, 1) == 1, 1'b0, 32'd0);
        end

        // Reset in the middle of a divide: unit returns to idle and never completes it.
        op    = 3'd5;
        d1    = 32'd100;
        d2    = 32'd7;
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_ready", {31'b0, ready_o}, 32'd1);
        check("abort_data", data_o, 32'd0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid_o) pulses++;
        end
        check("abort_no_valid", pulses, 0);

        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, 32'hFFFF_FFFD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
